// File: rtl/ami_mem_responder_if.sv
// AMI request/response bus between a requester (master) and the memory responder (slave).
// Each direction uses valid/grant handshaking; a transfer happens on valid && grant.
interface ami_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512,
    parameter int SIZE_W = 7
);
    logic              req_valid;
    logic              req_is_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [SIZE_W-1:0] req_size;
    logic              req_grant;
    logic              resp_valid;
    logic              resp_is_write;
    logic [DATA_W-1:0] resp_data;
    logic              resp_grant;

    modport slave (
        input  req_valid, req_is_write, req_addr, req_data, req_size, resp_grant,
        output req_grant, resp_valid, resp_is_write, resp_data
    );

    modport master (
        output req_valid, req_is_write, req_addr, req_data, req_size, resp_grant,
        input  req_grant, resp_valid, resp_is_write, resp_data
    );
endinterface

// File: rtl/ami_mem_responder.sv
// Word-addressed memory model answering AMI requests in order; array zeroed unless AMI_MEM_PRELOAD_EN.
// Latency: response visible LATENCY cycles after accept (fixed pipeline, then FWFT FIFO).
// Backpressure: registered req_grant drops once RESP_DEPTH responses are outstanding.
module ami_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int SIZE_W     = 7,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4,
    parameter int RESP_DEPTH = 8,
    parameter     MEM_FILE   = "dnnweaver_mem.txt"
) (
    input  logic                 clk,
    input  logic                 rst,
    ami_mem_responder_if.slave   bus,
    output logic                 err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic             grant_q;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_nxt;
    logic [IDX_W-1:0] idx;
    logic [MA_W-1:0]  mem_addr;
    logic             in_range;
    logic             acc;
    logic             pop;
    logic             push_vld;
    resp_t            in_entry;
    resp_t            push_dat;
    logic             unused_addr_bits;

    assign acc              = bus.req_valid && grant_q;
    assign idx              = bus.req_addr[ADDR_W-1:OFF_W];
    assign in_range         = (idx < IDX_W'(MEM_WORDS));
    assign mem_addr         = idx[MA_W-1:0];
    assign unused_addr_bits = ^bus.req_addr[OFF_W-1:0];

`ifndef AMI_MEM_PRELOAD_EN
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    end
`endif

    // Read data is captured at the accept edge, so later writes never leak into it.
    always_comb begin
        in_entry          = '0;
        in_entry.is_write = bus.req_is_write;
        if (!bus.req_is_write && in_range) in_entry.data = mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (acc && bus.req_is_write && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (b < int'(bus.req_size)) mem[mem_addr][b*8 +: 8] <= bus.req_data[b*8 +: 8];
            end
        end
    end

    // LATENCY-1 register stages; the FIFO write supplies the final stage.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_vld = acc;
            assign push_dat = in_entry;
        end else begin : g_pipe
            localparam int ST = LATENCY - 1;
            logic  pipe_vld [ST];
            resp_t pipe_dat [ST];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < ST; i++) pipe_vld[i] <= 1'b0;
                end else begin
                    pipe_vld[0] <= acc;
                    for (int i = 1; i < ST; i++) pipe_vld[i] <= pipe_vld[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pipe_dat[0] <= in_entry;
                for (int i = 1; i < ST; i++) pipe_dat[i] <= pipe_dat[i-1];
            end

            assign push_vld = pipe_vld[ST-1];
            assign push_dat = pipe_dat[ST-1];
        end
    endgenerate

    resp_t            fifo [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_vld;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_vld = (fifo_cnt != '0);
    assign pop      = fifo_vld && bus.resp_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)      rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push_vld) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) fifo[wr_ptr] <= push_dat;
    end

    assign bus.resp_valid    = fifo_vld;
    assign bus.resp_is_write = fifo_vld & fifo[rd_ptr].is_write;
    assign bus.resp_data     = fifo_vld ? fifo[rd_ptr].data : '0;
    assign bus.req_grant     = grant_q;

    // Credits cover pipeline and FIFO together, so the FIFO can never overflow.
    always_comb begin
        out_nxt = out_cnt + CNT_W'(acc) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= '0;
            grant_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            out_cnt <= out_nxt;
            grant_q <= (out_nxt < CNT_W'(RESP_DEPTH));
            if (acc && !in_range) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ami_mem_responder.sv
// Bench for ami_mem_responder: directed scenarios plus randomized traffic against a queue/array model.
module tb_ami_mem_responder;
    localparam int ADDR_W = 32, DATA_W = 512, SIZE_W = 7;
    localparam int MEM_WORDS = 4096, LATENCY = 4, RESP_DEPTH = 8, BYTES = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        bit    w;
        word_t d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    ami_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

    ami_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .err(err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t mdl [int];
    exp_t  expq [$];

    function automatic word_t mdl_rd(input int idx);
        if (idx < MEM_WORDS && mdl.exists(idx)) return mdl[idx];
        return '0;
    endfunction

    function automatic word_t rnd_word();
        word_t r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drives one request once grant is seen and records the expected response.
    task automatic do_req(input bit w, input logic [31:0] addr, input word_t d, input int size, output bit ok);
        int    t = 0;
        int    idx;
        int    n;
        word_t cur;
        exp_t  e;
        while (bus.req_grant !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        ok = (bus.req_grant === 1'b1);
        if (!ok) return;
        bus.req_valid    = 1'b1;
        bus.req_is_write = w;
        bus.req_addr     = addr;
        bus.req_data     = d;
        bus.req_size     = SIZE_W'(size);
        @(posedge clk);
        idx = int'(addr / BYTES);
        e.w = w;
        e.d = '0;
        if (w) begin
            if (idx < MEM_WORDS) begin
                cur = mdl_rd(idx);
                n = (size < BYTES) ? size : BYTES;
                for (int b = 0; b < n; b++) cur[b*8 +: 8] = d[b*8 +: 8];
                mdl[idx] = cur;
            end
        end else begin
            e.d = mdl_rd(idx);
        end
        expq.push_back(e);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic pop_one(output bit w, output word_t d, output bit ok);
        int t = 0;
        while (bus.resp_valid !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        ok = (bus.resp_valid === 1'b1);
        w  = bus.resp_is_write;
        d  = bus.resp_data;
        if (!ok) return;
        bus.resp_grant = 1'b1;
        @(posedge clk);
        #1 bus.resp_grant = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        #2;
        n_checks++;
        if (bus.req_grant !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_is_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b vld=%b isw=%b want 0 0 0", bus.req_grant, bus.resp_valid, bus.resp_is_write);
        end
        n_checks++;
        if (bus.resp_data !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h err=%b want 0 0", bus.resp_data, err);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_grant: got %b want 1", bus.req_grant);
        end
        ok = 1'b1;
    endtask

    task automatic test_write_read();
        bit ok; bit w; word_t d; exp_t e;
        do_req(1'b1, 32'h40, {BYTES{8'hA5}}, 64, ok);
        do_req(1'b0, 32'h40, '0, 0, ok);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            pop_one(w, d, ok);
            n_checks++;
            if (!ok || w !== e.w || d !== e.d) begin
                n_fail++;
                $display("FAIL write_read: got w=%b d=%h want w=%b d=%h", w, d, e.w, e.d);
            end
        end
        n_checks++;
        if (d !== {BYTES{8'hA5}}) begin
            n_fail++;
            $display("FAIL write_read_const: got %h want all a5", d);
        end
    endtask

    task automatic test_partial();
        bit ok; bit w; word_t d; exp_t e;
        do_req(1'b1, 32'h80, {BYTES{8'h11}}, 64, ok);
        do_req(1'b1, 32'h80, {BYTES{8'hFF}}, 8, ok);
        do_req(1'b0, 32'h80, '0, 0, ok);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            pop_one(w, d, ok);
            n_checks++;
            if (!ok || w !== e.w || d !== e.d) begin
                n_fail++;
                $display("FAIL partial: got w=%b d=%h want w=%b d=%h", w, d, e.w, e.d);
            end
        end
        n_checks++;
        if (d !== {{56{8'h11}}, {8{8'hFF}}}) begin
            n_fail++;
            $display("FAIL partial_const: got %h", d);
        end
    endtask

    task automatic test_latency();
        bit ok; int n = 0; exp_t e; word_t d;
        bus.resp_grant = 1'b1;
        do_req(1'b0, 32'h80, '0, 0, ok);
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        d = bus.resp_data;
        @(posedge clk); #1 bus.resp_grant = 1'b0;
        e = expq.pop_front();
        // n counts cycles after the accept cycle, so the total latency is n+1.
        n_checks++;
        if (n + 1 != LATENCY) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want %0d", n + 1, LATENCY);
        end
        n_checks++;
        if (d !== e.d) begin
            n_fail++;
            $display("FAIL latency_data: got %h want %h", d, e.d);
        end
    endtask

    task automatic test_backpressure();
        bit ok; bit w; word_t d; exp_t e; int hi = 0; int acc = 0;
        for (int i = 0; i < 9; i++) do_req(1'b1, 32'((20 + i) * BYTES), rnd_word(), 64, ok);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            pop_one(w, d, ok);
        end
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 32'((20 + i) * BYTES), '0, 0, ok);
            if (ok) acc++;
        end
        n_checks++;
        if (acc != 8 || bus.req_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fill: got accepted=%0d grant=%b want 8 0", acc, bus.req_grant);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.req_grant !== 1'b0) hi++;
        end
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got grant high %0d cycles want 0", hi);
        end
        e = expq.pop_front();
        pop_one(w, d, ok);
        n_checks++;
        if (!ok || d !== e.d || bus.req_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop_credit: got grant=%b d=%h want grant=1 d=%h", bus.req_grant, d, e.d);
        end
        do_req(1'b0, 32'(28 * BYTES), '0, 0, ok);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            pop_one(w, d, ok);
            n_checks++;
            if (!ok || w !== e.w || d !== e.d) begin
                n_fail++;
                $display("FAIL bp_order: got w=%b d=%h want w=%b d=%h", w, d, e.w, e.d);
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 150;
        fork
            begin
                bit ok; bit w; int idx; int size;
                for (int i = 0; i < N; i++) begin
                    w    = 1'($urandom % 2);
                    idx  = 40 + int'($urandom % 16);
                    size = ($urandom % 4 == 0) ? 64 : int'($urandom % 80);
                    do_req(w, 32'(idx * BYTES + int'($urandom % BYTES)), rnd_word(), size, ok);
                    if (!ok) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand_req_timeout: got no grant want grant at op %0d", i);
                    end
                end
            end
            begin
                int got = 0; int cyc = 0; bit g; bit v; bit w; word_t d;
                bit pv = 1'b0; bit pg = 1'b0; bit pw = 1'b0; word_t pd = '0; exp_t e;
                while (got < N && cyc < 5000) begin
                    v = bus.resp_valid; w = bus.resp_is_write; d = bus.resp_data;
                    if (pv && !pg) begin
                        n_checks++;
                        if (v !== 1'b1 || w !== pw || d !== pd) begin
                            n_fail++;
                            $display("FAIL rand_hold: got v=%b w=%b d=%h want v=1 w=%b d=%h", v, w, d, pw, pd);
                        end
                    end
                    g = ($urandom % 3 != 0);
                    bus.resp_grant = g;
                    @(posedge clk); #1; cyc++;
                    pv = v; pg = g; pw = w; pd = d;
                    if (v && g) begin
                        got++;
                        n_checks++;
                        if (expq.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_extra: got unexpected response d=%h want none", d);
                        end else begin
                            e = expq.pop_front();
                            if (w !== e.w || d !== e.d) begin
                                n_fail++;
                                $display("FAIL rand_resp: got w=%b d=%h want w=%b d=%h", w, d, e.w, e.d);
                            end
                        end
                    end
                end
                bus.resp_grant = 1'b0;
                n_checks++;
                if (got != N) begin
                    n_fail++;
                    $display("FAIL rand_count: got %0d responses want %0d", got, N);
                end
            end
        join
    endtask

    task automatic test_oob();
        bit ok; bit w; word_t d; exp_t e;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_err_pre: got %b want 0", err);
        end
        do_req(1'b0, 32'(MEM_WORDS * BYTES), '0, 0, ok);
        e = expq.pop_front();
        pop_one(w, d, ok);
        n_checks++;
        if (!ok || w !== 1'b0 || d !== '0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_read: got w=%b d=%h err=%b want w=0 d=0 err=1", w, d, err);
        end
        do_req(1'b1, 32'(MEM_WORDS * BYTES), rnd_word(), 64, ok);
        do_req(1'b0, 32'h0, '0, 0, ok);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            pop_one(w, d, ok);
            n_checks++;
            if (!ok || w !== e.w || d !== e.d) begin
                n_fail++;
                $display("FAIL oob_write: got w=%b d=%h want w=%b d=%h", w, d, e.w, e.d);
            end
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok; bit w; word_t d; exp_t e; int hi = 0;
        do_req(1'b1, 32'h1000, rnd_word(), 64, ok);
        e = expq.pop_front();
        pop_one(w, d, ok);
        for (int i = 0; i < 3; i++) do_req(1'b0, 32'h1000, '0, 0, ok);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_grant !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got vld=%b grant=%b err=%b want 0 0 0", bus.resp_valid, bus.req_grant, err);
        end
        expq.delete();
        @(negedge clk) rst = 1'b1;
        bus.resp_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b0) hi++;
        end
        bus.resp_grant = 1'b0;
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL midreset_drop: got %0d stale responses want 0", hi);
        end
        do_req(1'b0, 32'h1000, '0, 0, ok);
        e = expq.pop_front();
        pop_one(w, d, ok);
        n_checks++;
        if (!ok || w !== 1'b0 || d !== e.d) begin
            n_fail++;
            $display("FAIL midreset_retain: got d=%h want %h", d, e.d);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_is_write = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_size     = '0;
        bus.resp_grant   = 1'b0;
        test_reset();
        test_write_read();
        test_partial();
        test_latency();
        test_backpressure();
        test_random();
        test_oob();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
